exception_unit: RTL
===================

Name: exception_unit

Overview:
- Collects per-stage exception flags (RI and SYSCALL from decode, OVF from execute) and carries them down the pipeline with their PCs.
- Raises them precisely, in program order, when the faulting instruction reaches the commit point.
- Drives the 67-bit exception bus consumed by coprocessor 0 and tracks handler entry/exit (ERET) with a small state machine.
- Sits between the ID/EX pipeline stages and the coprocessor.

Parameters:
- CNT_W, 8, width of the saturating committed-exception counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; stage registers keep their contents.
- flush  in  1  external squash (branch redirect or coprocessor cop_reset); clears all stage valids.
- id_valid  in  1  decode slot holds a real instruction.
- id_ri  in  1  decode detected reserved instruction.
- id_syscall  in  1  decode detected syscall.
- id_pc  in  32  PC of the decode instruction.
- id_instr  in  32  instruction word in decode.
- ex_ovf  in  1  arithmetic overflow for the instruction currently in EX.
- eret  in  1  ERET committed; handler exit.
- exception_bus  out  67  [66]=OVF, [65]=RI, [64]=SYSCALL, [63:32]=EPC, [31:0]=bad-instruction word.
- exc_flush  out  1  squash younger instructions; coincides with the bus pulse.
- in_handler  out  1  high from the raise until ERET.
- nested_err  out  1  sticky; an exception committed while in_handler.
- exc_count  out  CNT_W  number of exceptions raised, saturating.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, both stage valids are 0, and the state is IDLE.
- Stage registers:
  - S_EX is loaded from the ID inputs when stall=0: valid, ri, syscall, pc, instr.
  - S_MEM is loaded from S_EX when stall=0. ovf is captured as S_EX.valid & ex_ovf.
  - When stall=1, both stages hold. ex_ovf is sampled only on an advancing edge.
- Commit condition: commit = S_MEM.valid & (ovf|ri|syscall).
  - commit is evaluated every cycle, including while stalled.
  - A given S_MEM entry commits once. S_MEM.valid clears on the raise edge.
- Priority within one slot: OVF > RI > SYSCALL. The bus always carries exactly one flag bit set (one-hot).
- Older instructions win automatically because only S_MEM commits.
- States:
  - IDLE: on commit, go to RAISE at the next edge and register the bus fields:
    - flag one-hot;
    - EPC = S_MEM.pc;
    - [31:0] = S_MEM.instr if RI, else 0.
    - On the same edge, clear the S_EX and S_MEM valids (self-flush of younger instructions).
  - RAISE: lasts exactly 1 cycle.
    - exception_bus is non-zero and exc_flush=1.
    - exc_count increments, saturating at all-ones.
    - Next state is HANDLER. At the following edge the bus returns to all-zero and exc_flush=0.
  - HANDLER: in_handler=1.
    - eret=1 returns the state to IDLE at the next edge.
    - A commit here does not drive the bus. It sets nested_err (sticky until reset), clears S_MEM.valid, and leaves the state unchanged.
    - eret and commit in the same cycle: eret wins. The state goes to IDLE and the commit is discarded, with no nested_err.
  - eret in IDLE or RAISE is ignored.
- flush=1: both stage valids clear at the next edge and override any load from ID.
  - A commit present in the same cycle as flush is still raised. Commit has priority because the faulting instruction is older than the flush cause.
- Reset asserted mid-RAISE: the bus drops to 0 immediately, without waiting for a clock edge.
- The bus is fully registered and carries no combinational path from the inputs.

Test Plan:
- SYSCALL at ID: id_valid=1, id_syscall=1, id_pc=0x00400010, no stall. The ID edge is edge 0, S_MEM is loaded at edge 1, and the raise is registered at edge 2. After edge 2 the bus is 0x1_00400010_00000000 (bit 64 set), exc_flush=1 for one cycle, and exc_count=1.
- RI at 0x00400020, instr 0xFC000000. Required: bus[65]=1, [63:32]=0x00400020, [31:0]=0xFC000000, then in_handler=1. Following eret: in_handler=0 one cycle later.
- OVF on an instruction that also carries a syscall flag. Required: only bit 66 set. Second case: two back-to-back faulting instructions. Required: only the older one is raised, and the younger is squashed with no second pulse.
- Stall held for 3 cycles with a fault in S_EX. Required: no raise until stall drops. Second case: ex_ovf pulsed while stalled and dropped before the advance. Required: no OVF is raised.
- While in HANDLER, commit an RI. Required: the bus stays 0 and nested_err=1. Second case: eret and commit in the same cycle. Required: IDLE is reached and nested_err is unchanged.
- Reset pulled low during RAISE. Required: the bus, exc_count and in_handler all read 0 before the next clk edge. Second case: 260 exceptions with CNT_W=8. Required: exc_count saturates at 255.

Source files
------------

// File: rtl/exception_if.sv
// Pipeline-side and coprocessor-side signals of the exception unit.
// The pipeline/testbench drives through master; exception_unit receives through slave.
interface exception_if #(
    parameter int unsigned CNT_W = 8
);
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic             id_ri;
    logic             id_syscall;
    logic [31:0]      id_pc;
    logic [31:0]      id_instr;
    logic             ex_ovf;
    logic             eret;
    logic [66:0]      exception_bus;
    logic             exc_flush;
    logic             in_handler;
    logic             nested_err;
    logic [CNT_W-1:0] exc_count;

    modport master (
        output stall, flush, id_valid, id_ri, id_syscall, id_pc, id_instr, ex_ovf, eret,
        input  exception_bus, exc_flush, in_handler, nested_err, exc_count
    );

    modport slave (
        input  stall, flush, id_valid, id_ri, id_syscall, id_pc, id_instr, ex_ovf, eret,
        output exception_bus, exc_flush, in_handler, nested_err, exc_count
    );
endinterface

// File: rtl/exception_unit.sv
// Carries decode/execute exception flags to the commit point and raises them precisely,
// one at a time, on a registered 67-bit bus; tracks handler entry and ERET.
module exception_unit #(
    parameter int unsigned CNT_W = 8
) (
    input logic        clk,
    input logic        reset,
    exception_if.slave exc
);
    typedef enum logic [1:0] {StIdle, StRaise, StHandler} state_e;

    state_e state_q, state_d;

    logic             ex_valid_q, ex_valid_d, ex_ri_q, ex_sys_q;
    logic [31:0]      ex_pc_q, ex_instr_q;
    logic             mem_valid_q, mem_valid_d, mem_ovf_q, mem_ri_q, mem_sys_q;
    logic [31:0]      mem_pc_q, mem_instr_q;
    logic [66:0]      bus_q, bus_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nested_q, nested_d;

    logic commit, take_raise, consume;

    assign commit     = mem_valid_q & (mem_ovf_q | mem_ri_q | mem_sys_q);
    assign take_raise = (state_q == StIdle) & commit;
    assign consume    = (state_q == StHandler) & commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (commit) state_d = StRaise;
            StRaise:   state_d = StHandler;
            StHandler: if (exc.eret) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        exc.exc_flush  = (state_q == StRaise);
        exc.in_handler = (state_q == StRaise) | (state_q == StHandler);
    end

    // A raise squashes everything younger; a flush never cancels the commit already in S_MEM.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        mem_valid_d = mem_valid_q;
        if (!exc.stall) begin
            ex_valid_d  = exc.id_valid;
            mem_valid_d = ex_valid_q;
        end else if (consume) begin
            mem_valid_d = 1'b0;
        end
        if (exc.flush || take_raise) begin
            ex_valid_d  = 1'b0;
            mem_valid_d = 1'b0;
        end
    end

    always_comb begin
        bus_d    = '0;
        cnt_d    = cnt_q;
        nested_d = nested_q | (consume & ~exc.eret);
        if (take_raise) begin
            if (mem_ovf_q)     bus_d[66:64] = 3'b100;
            else if (mem_ri_q) bus_d[66:64] = 3'b010;
            else               bus_d[66:64] = 3'b001;
            bus_d[63:32] = mem_pc_q;
            bus_d[31:0]  = (!mem_ovf_q && mem_ri_q) ? mem_instr_q : 32'h0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_ri_q     <= 1'b0;
            ex_sys_q    <= 1'b0;
            ex_pc_q     <= '0;
            ex_instr_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_ovf_q   <= 1'b0;
            mem_ri_q    <= 1'b0;
            mem_sys_q   <= 1'b0;
            mem_pc_q    <= '0;
            mem_instr_q <= '0;
            bus_q       <= '0;
            cnt_q       <= '0;
            nested_q    <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            mem_valid_q <= mem_valid_d;
            bus_q       <= bus_d;
            cnt_q       <= cnt_d;
            nested_q    <= nested_d;
            if (!exc.stall) begin
                ex_ri_q     <= exc.id_ri;
                ex_sys_q    <= exc.id_syscall;
                ex_pc_q     <= exc.id_pc;
                ex_instr_q  <= exc.id_instr;
                mem_ovf_q   <= ex_valid_q & exc.ex_ovf;
                mem_ri_q    <= ex_ri_q;
                mem_sys_q   <= ex_sys_q;
                mem_pc_q    <= ex_pc_q;
                mem_instr_q <= ex_instr_q;
            end
        end
    end

    assign exc.exception_bus = bus_q;
    assign exc.exc_count     = cnt_q;
    assign exc.nested_err    = nested_q;
endmodule
